// File: rtl/countdown_timer_if.sv
// Control/status bundle between the key/switch front end, the countdown core and the display logic.
// master = front end / bench side, slave = timer core.
interface countdown_timer_if #(
  parameter int LED_W = 10
);
  logic             clear;
  logic             load;
  logic [7:0]       preset_min;
  logic [7:0]       preset_sec;
  logic             start_stop;
  logic             auto_repeat;
  logic [7:0]       min_bcd;
  logic [7:0]       sec_bcd;
  logic [2:0]       state;
  logic             expired;
  logic [LED_W-1:0] alarm_led;

  modport master (
    output clear, load, preset_min, preset_sec, start_stop, auto_repeat,
    input  min_bcd, sec_bcd, state, expired, alarm_led
  );

  modport slave (
    input  clear, load, preset_min, preset_sec, start_stop, auto_repeat,
    output min_bcd, sec_bcd, state, expired, alarm_led
  );
endinterface

// File: rtl/countdown_timer_core.sv
// MM:SS BCD countdown engine with pause/resume, optional auto-repeat and a self-terminating
// flashing alarm. All outputs come straight from registers.
module countdown_timer_core #(
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int FLASH_TICKS   = 12_500_000,
  parameter int ALARM_SECS    = 10,
  parameter int LED_W         = 10
) (
  input  logic               clk,
  input  logic               reset_n,
  countdown_timer_if.slave   bus
);

  localparam int ALARM_CYCLES = ALARM_SECS * TICKS_PER_SEC;
  localparam int PW = $clog2(TICKS_PER_SEC);
  localparam int FW = $clog2(FLASH_TICKS + 1);
  localparam int AW = $clog2(ALARM_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOADED  = 3'd1,
    RUNNING = 3'd2,
    PAUSED  = 3'd3,
    ALARM   = 3'd4
  } state_t;

  state_t           state_reg, state_next;
  logic [7:0]       min_reg, min_next;
  logic [7:0]       sec_reg, sec_next;
  logic [7:0]       preset_min_reg, preset_min_next;
  logic [7:0]       preset_sec_reg, preset_sec_next;
  logic [PW-1:0]    presc_reg, presc_next;
  logic             expired_reg, expired_next;
  logic [LED_W-1:0] led_reg, led_next;
  logic [FW-1:0]    flash_reg, flash_next;
  logic [AW-1:0]    alarm_reg, alarm_next;

  // Preset sanitising: digit order is {min tens, min ones, sec tens, sec ones} = 3..0.
  logic [15:0] raw_preset;
  logic [3:0]  san_digit [4];
  logic [7:0]  san_min, san_sec;
  logic        san_zero;

  assign raw_preset = {bus.preset_min, bus.preset_sec};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sanitise
      localparam logic [3:0] DIGIT_MAX = (gi == 1) ? 4'd5 : 4'd9;
      assign san_digit[gi] = (raw_preset[gi*4 +: 4] > DIGIT_MAX) ? DIGIT_MAX
                                                                 : raw_preset[gi*4 +: 4];
    end
  endgenerate

  assign san_min  = {san_digit[3], san_digit[2]};
  assign san_sec  = {san_digit[1], san_digit[0]};
  assign san_zero = (san_min == 8'h00) && (san_sec == 8'h00);

  // One-second BCD decrement of the current time.
  logic [7:0] dec_min, dec_sec;
  logic       dec_zero;

  always_comb begin
    dec_min = min_reg;
    dec_sec = sec_reg;
    if (sec_reg[3:0] != 4'd0) begin
      dec_sec[3:0] = sec_reg[3:0] - 4'd1;
    end else if (sec_reg[7:4] != 4'd0) begin
      dec_sec = {sec_reg[7:4] - 4'd1, 4'd9};
    end else begin
      dec_sec = 8'h59;
      if (min_reg[3:0] != 4'd0) begin
        dec_min[3:0] = min_reg[3:0] - 4'd1;
      end else if (min_reg[7:4] != 4'd0) begin
        dec_min = {min_reg[7:4] - 4'd1, 4'd9};
      end else begin
        dec_min = 8'h00;
        dec_sec = 8'h00;
      end
    end
    dec_zero = (dec_min == 8'h00) && (dec_sec == 8'h00);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      min_reg        <= 8'h00;
      sec_reg        <= 8'h00;
      preset_min_reg <= 8'h00;
      preset_sec_reg <= 8'h00;
      presc_reg      <= '0;
      expired_reg    <= 1'b0;
      led_reg        <= '0;
      flash_reg      <= '0;
      alarm_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      min_reg        <= min_next;
      sec_reg        <= sec_next;
      preset_min_reg <= preset_min_next;
      preset_sec_reg <= preset_sec_next;
      presc_reg      <= presc_next;
      expired_reg    <= expired_next;
      led_reg        <= led_next;
      flash_reg      <= flash_next;
      alarm_reg      <= alarm_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    min_next        = min_reg;
    sec_next        = sec_reg;
    preset_min_next = preset_min_reg;
    preset_sec_next = preset_sec_reg;
    presc_next      = presc_reg;
    expired_next    = 1'b0;
    led_next        = led_reg;
    flash_next      = flash_reg;
    alarm_next      = alarm_reg;

    if (bus.clear) begin
      state_next = IDLE;
      min_next   = 8'h00;
      sec_next   = 8'h00;
      presc_next = '0;
      led_next   = '0;
      flash_next = '0;
      alarm_next = '0;
    end else begin
      case (state_reg)
        IDLE, LOADED, PAUSED: begin
          if (bus.load) begin
            preset_min_next = san_min;
            preset_sec_next = san_sec;
            min_next        = san_min;
            sec_next        = san_sec;
            state_next      = san_zero ? IDLE : LOADED;
          end else if (bus.start_stop && state_reg == LOADED) begin
            state_next = RUNNING;
            presc_next = '0;
          end else if (bus.start_stop && state_reg == PAUSED) begin
            state_next = RUNNING;
          end
        end

        RUNNING: begin
          // The prescaler advances on every RUNNING cycle, including the one that pauses.
          if (presc_reg == PW'(TICKS_PER_SEC - 1)) begin
            presc_next = '0;
            min_next   = dec_min;
            sec_next   = dec_sec;
            if (dec_zero) begin
              expired_next = 1'b1;
              if (bus.auto_repeat) begin
                min_next = preset_min_reg;
                sec_next = preset_sec_reg;
              end else begin
                state_next = ALARM;
                led_next   = '1;
                flash_next = '0;
                alarm_next = '0;
              end
            end
          end else begin
            presc_next = presc_reg + 1'b1;
          end
          if (bus.start_stop && state_next == RUNNING) begin
            state_next = PAUSED;
          end
        end

        ALARM: begin
          if (bus.start_stop || alarm_reg == AW'(ALARM_CYCLES - 1)) begin
            state_next = IDLE;
            led_next   = '0;
            min_next   = 8'h00;
            sec_next   = 8'h00;
          end else begin
            alarm_next = alarm_reg + 1'b1;
            if (flash_reg == FW'(FLASH_TICKS - 1)) begin
              flash_next = '0;
              led_next   = ~led_reg;
            end else begin
              flash_next = flash_reg + 1'b1;
            end
          end
        end

        default: begin
          state_next = IDLE;
          led_next   = '0;
        end
      endcase
    end
  end

  assign bus.min_bcd   = min_reg;
  assign bus.sec_bcd   = sec_reg;
  assign bus.state     = state_reg;
  assign bus.expired   = expired_reg;
  assign bus.alarm_led = led_reg;

endmodule

// File: tb/tb_countdown_timer_core.sv
// Directed bench for countdown_timer_core with short timing parameters
// (4 clocks per second, 2-clock flash, 2-second alarm).
module tb_countdown_timer_core;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_errors;

  countdown_timer_if #(.LED_W(4)) bus ();

  countdown_timer_core #(
    .TICKS_PER_SEC(4),
    .FLASH_TICKS  (2),
    .ALARM_SECS   (2),
    .LED_W        (4)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("check %s: got %0h ok", tag, got);
    end
  endtask

  // Advance n clock edges and land 1 time unit after the last one.
  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_load(input logic [7:0] pm, input logic [7:0] ps);
    bus.preset_min = pm;
    bus.preset_sec = ps;
    bus.load       = 1'b1;
    wait_edges(1);
    bus.load       = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start_stop = 1'b1;
    wait_edges(1);
    bus.start_stop = 1'b0;
  endtask

  task automatic pulse_clear();
    bus.clear = 1'b1;
    wait_edges(1);
    bus.clear = 1'b0;
  endtask

  task automatic check_time(input string tag, input logic [7:0] m, input logic [7:0] s);
    check({tag, ".min"}, bus.min_bcd, m);
    check({tag, ".sec"}, bus.sec_bcd, s);
  endtask

  initial begin
    n_checks        = 0;
    n_errors        = 0;
    reset_n         = 1'b0;
    bus.clear       = 1'b0;
    bus.load        = 1'b0;
    bus.start_stop  = 1'b0;
    bus.auto_repeat = 1'b0;
    bus.preset_min  = 8'h00;
    bus.preset_sec  = 8'h00;

    // 1: reset
    wait_edges(3);
    reset_n = 1'b1;
    wait_edges(1);
    check("rst.state", bus.state, 3'd0);
    check_time("rst", 8'h00, 8'h00);
    check("rst.led", bus.alarm_led, 4'h0);
    check("rst.expired", bus.expired, 1'b0);

    // 2: 00:03 countdown into alarm, alarm self-terminates
    pulse_load(8'h00, 8'h03);
    check("t2.loaded", bus.state, 3'd1);
    check_time("t2.load", 8'h00, 8'h03);
    pulse_start();
    check("t2.running", bus.state, 3'd2);
    wait_edges(3);
    check_time("t2.c3", 8'h00, 8'h03);
    wait_edges(1);
    check_time("t2.c4", 8'h00, 8'h02);
    wait_edges(4);
    check_time("t2.c8", 8'h00, 8'h01);
    wait_edges(3);
    check("t2.c11.expired", bus.expired, 1'b0);
    wait_edges(1);
    check_time("t2.c12", 8'h00, 8'h00);
    check("t2.c12.expired", bus.expired, 1'b1);
    check("t2.c12.state", bus.state, 3'd4);
    check("t2.a0.led", bus.alarm_led, 4'hF);
    for (int i = 1; i <= 7; i++) begin
      wait_edges(1);
      check($sformatf("t2.a%0d.state", i), bus.state, 3'd4);
      check($sformatf("t2.a%0d.led", i), bus.alarm_led, ((i / 2) % 2 == 0) ? 4'hF : 4'h0);
      if (i == 1) check("t2.a1.expired", bus.expired, 1'b0);
    end
    wait_edges(1);
    check("t2.a8.state", bus.state, 3'd0);
    check("t2.a8.led", bus.alarm_led, 4'h0);
    check_time("t2.a8", 8'h00, 8'h00);

    // 3: pause keeps the prescaler; resume finishes the partial second
    pulse_load(8'h01, 8'h00);
    pulse_start();
    wait_edges(4);
    check_time("t3.c4", 8'h00, 8'h59);
    wait_edges(1);
    pulse_start();
    check("t3.paused", bus.state, 3'd3);
    wait_edges(20);
    check("t3.hold.state", bus.state, 3'd3);
    check_time("t3.hold", 8'h00, 8'h59);
    pulse_start();
    check("t3.resumed", bus.state, 3'd2);
    wait_edges(1);
    check_time("t3.r1", 8'h00, 8'h59);
    wait_edges(1);
    check_time("t3.r2", 8'h00, 8'h58);
    pulse_clear();
    check("t3.clear.state", bus.state, 3'd0);
    check_time("t3.clear", 8'h00, 8'h00);

    // 4: preset sanitising
    pulse_load(8'hAF, 8'h7C);
    check_time("t4", 8'h99, 8'h59);
    check("t4.state", bus.state, 3'd1);
    pulse_load(8'h3B, 8'h6A);
    check_time("t4b", 8'h39, 8'h59);
    pulse_clear();

    // 5: auto-repeat reloads on expiry and keeps running
    bus.auto_repeat = 1'b1;
    pulse_load(8'h00, 8'h02);
    pulse_start();
    wait_edges(7);
    check("t5.c7.expired", bus.expired, 1'b0);
    check_time("t5.c7", 8'h00, 8'h01);
    wait_edges(1);
    check("t5.c8.expired", bus.expired, 1'b1);
    check("t5.c8.state", bus.state, 3'd2);
    check_time("t5.c8", 8'h00, 8'h02);
    wait_edges(1);
    check("t5.c9.expired", bus.expired, 1'b0);
    wait_edges(7);
    check("t5.c16.expired", bus.expired, 1'b1);
    check("t5.c16.state", bus.state, 3'd2);
    check_time("t5.c16", 8'h00, 8'h02);
    pulse_clear();
    bus.auto_repeat = 1'b0;
    check("t5.clear.state", bus.state, 3'd0);
    check_time("t5.clear", 8'h00, 8'h00);

    // 6: priorities, ignored pulses, alarm acknowledge
    bus.clear = 1'b1;
    pulse_load(8'h00, 8'h05);
    bus.clear = 1'b0;
    check("t6.clrload.state", bus.state, 3'd0);
    check_time("t6.clrload", 8'h00, 8'h00);
    pulse_load(8'h00, 8'h00);
    check("t6.zero.state", bus.state, 3'd0);
    pulse_start();
    check("t6.idle_start.state", bus.state, 3'd0);
    pulse_load(8'h00, 8'h05);
    pulse_start();
    pulse_load(8'h00, 8'h09);
    check("t6.runload.state", bus.state, 3'd2);
    check_time("t6.runload", 8'h00, 8'h05);
    wait_edges(19);
    check("t6.expiry.state", bus.state, 3'd4);
    check("t6.expiry.expired", bus.expired, 1'b1);
    pulse_start();
    check("t6.ack.state", bus.state, 3'd0);
    check("t6.ack.led", bus.alarm_led, 4'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
